// File: rtl/starfield_pkg.sv
// Shared definitions for the starfield compositor: CPU register map,
// control bit positions and fade state encoding.
package starfield_pkg;

   localparam logic SF_REG_CTRL = 1'b0;
   localparam logic SF_REG_TINT = 1'b1;

   localparam int SF_CTRL_STAR_EN  = 0;
   localparam int SF_CTRL_FADE_DIR = 1;

   localparam int SF_TINT_R = 2;
   localparam int SF_TINT_G = 1;
   localparam int SF_TINT_B = 0;

   typedef enum logic {
      SF_FADE_IDLE = 1'b0,
      SF_FADE_RUN  = 1'b1
   } sf_fade_t;

endpackage

// File: rtl/starfield_fade.sv
// Frame-rate brightness ramp: vblank edge detect, IDLE/FADING state machine and
// a level that steps toward 0 or 255 once per frame, saturating at the target.
module starfield_fade
   import starfield_pkg::*;
#(
   parameter logic [7:0] FADE_STEP = 8'd4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic       vblank,
   input  logic       start,
   input  logic       dir,
   output logic [7:0] level,
   output logic       fading
);

   sf_fade_t   state, state_nxt;
   logic [7:0] level_nxt;
   logic       dir_q, dir_nxt;
   logic       vblank_d;
   logic       rise;
   logic [7:0] target;
   logic [7:0] stepped;

   function automatic logic [7:0] sat_step(input logic [7:0] lvl, input logic up);
      logic signed [9:0] sum;
      if (up) sum = $signed({2'b00, lvl}) + $signed({2'b00, FADE_STEP});
      else    sum = $signed({2'b00, lvl}) - $signed({2'b00, FADE_STEP});
      if (sum > 10'sd255)     return 8'hFF;
      else if (sum < 10'sd0)  return 8'h00;
      else                    return sum[7:0];
   endfunction

   assign rise    = en & vblank & ~vblank_d;
   assign target  = dir_q ? 8'hFF : 8'h00;
   assign stepped = sat_step(level, dir_q);
   assign fading  = (state == SF_FADE_RUN);

   // A step already at the target saturates onto it, so the "hold one frame,
   // then go idle" case falls out of the normal step rule.
   always_comb begin
      state_nxt = state;
      level_nxt = level;
      dir_nxt   = dir_q;
      if (start) begin
         state_nxt = SF_FADE_RUN;
         dir_nxt   = dir;
      end else if (state == SF_FADE_RUN && rise) begin
         level_nxt = stepped;
         if (stepped == target) state_nxt = SF_FADE_IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= SF_FADE_IDLE;
         level    <= 8'h00;
         dir_q    <= 1'b0;
         vblank_d <= 1'b0;
      end else begin
         state <= state_nxt;
         level <= level_nxt;
         dir_q <= dir_nxt;
         if (en) vblank_d <= vblank;
      end
   end

endmodule

// File: rtl/starfield_compositor.sv
// Two-stage pixel compositor: foreground over tinted, faded stars, with blanking.
// Hosts the CPU control/tint registers and the frame fade sub-block.
module starfield_compositor
   import starfield_pkg::*;
#(
   parameter logic [7:0] FADE_STEP  = 8'd4,
   parameter logic [2:0] TINT_RESET = 3'b111
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic       vblank,
   input  logic       hblank,
   input  logic       sf_on,
   input  logic [7:0] sf_star,
   input  logic       fg_on,
   input  logic [7:0] fg_r,
   input  logic [7:0] fg_g,
   input  logic [7:0] fg_b,
   input  logic       addr,
   input  logic [7:0] data_in,
   input  logic       write,
   output logic [7:0] r,
   output logic [7:0] g,
   output logic [7:0] b,
   output logic       blank_out,
   output logic       fading
);

   logic       star_en;
   logic [2:0] tint;
   logic       ctrl_wr;
   logic [7:0] level;
   logic       unused_data;

   logic       sf_on_p1, fg_on_p1, blank_p1;
   logic [7:0] sf_star_p1, fg_r_p1, fg_g_p1, fg_b_p1;
   logic [7:0] lum_p1;
   logic [7:0] mix_r, mix_g, mix_b;

   // Truncating scale: 255 maps a nonzero star to star-1, which is acceptable.
   function automatic logic [7:0] scale_lum(input logic [7:0] star, input logic [7:0] lvl);
      return 8'((16'(star) * 16'(lvl)) >> 8);
   endfunction

   assign ctrl_wr     = write & (addr == SF_REG_CTRL);
   assign unused_data = &{1'b0, data_in[7:3]};

   starfield_fade #(.FADE_STEP(FADE_STEP)) u_fade (
      .clk    (clk),
      .rst    (rst),
      .en     (en),
      .vblank (vblank),
      .start  (ctrl_wr),
      .dir    (data_in[SF_CTRL_FADE_DIR]),
      .level  (level),
      .fading (fading)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         star_en <= 1'b0;
         tint    <= TINT_RESET;
      end else if (write) begin
         if (addr == SF_REG_CTRL) star_en <= data_in[SF_CTRL_STAR_EN];
         else                     tint    <= data_in[2:0];
      end
   end

   // Stage 1: capture raw pixel inputs
   always_ff @(posedge clk) begin
      if (rst) begin
         sf_on_p1   <= 1'b0;
         sf_star_p1 <= 8'h00;
         fg_on_p1   <= 1'b0;
         fg_r_p1    <= 8'h00;
         fg_g_p1    <= 8'h00;
         fg_b_p1    <= 8'h00;
         blank_p1   <= 1'b1;
      end else if (en) begin
         sf_on_p1   <= sf_on;
         sf_star_p1 <= sf_star;
         fg_on_p1   <= fg_on;
         fg_r_p1    <= fg_r;
         fg_g_p1    <= fg_g;
         fg_b_p1    <= fg_b;
         blank_p1   <= hblank | vblank;
      end
   end

   // Stage 2: scale, tint and priority-mix using live register values
   assign lum_p1 = scale_lum(sf_star_p1, level);

   always_comb begin
      mix_r = 8'h00;
      mix_g = 8'h00;
      mix_b = 8'h00;
      if (blank_p1) begin
         mix_r = 8'h00;
      end else if (fg_on_p1) begin
         mix_r = fg_r_p1;
         mix_g = fg_g_p1;
         mix_b = fg_b_p1;
      end else if (star_en && sf_on_p1) begin
         mix_r = tint[SF_TINT_R] ? lum_p1 : 8'h00;
         mix_g = tint[SF_TINT_G] ? lum_p1 : 8'h00;
         mix_b = tint[SF_TINT_B] ? lum_p1 : 8'h00;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r         <= 8'h00;
         g         <= 8'h00;
         b         <= 8'h00;
         blank_out <= 1'b1;
      end else if (en) begin
         r         <= mix_r;
         g         <= mix_g;
         b         <= mix_b;
         blank_out <= blank_p1;
      end
   end

endmodule

// File: tb/tb_starfield_compositor.sv
// Directed-plus-random bench for starfield_compositor with a frame-level fade
// model and a pixel priority model.
module tb_starfield_compositor;

   logic       clk = 1'b0;
   logic       rst, en, vblank, hblank, sf_on, fg_on, addr, write;
   logic [7:0] sf_star, fg_r, fg_g, fg_b, data_in;
   logic [7:0] r, g, b;
   logic       blank_out, fading;

   int vectors     = 0;
   int miscompares = 0;

   int         m_level;
   bit         m_fading, m_up, m_sen;
   logic [2:0] m_tint;

   typedef struct {
      logic       hb;
      logic       son;
      logic [7:0] star;
      logic       fon;
      logic [7:0] fr, fgg, fbb;
   } px_t;

   px_t q[$];

   always #5 clk = ~clk;

   starfield_compositor dut (
      .clk(clk), .rst(rst), .en(en), .vblank(vblank), .hblank(hblank),
      .sf_on(sf_on), .sf_star(sf_star), .fg_on(fg_on),
      .fg_r(fg_r), .fg_g(fg_g), .fg_b(fg_b),
      .addr(addr), .data_in(data_in), .write(write),
      .r(r), .g(g), .b(b), .blank_out(blank_out), .fading(fading)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic px_t rand_px();
      px_t p;
      p.hb   = ($urandom_range(0, 3) == 0);
      p.son  = $urandom_range(0, 1) == 1;
      p.star = 8'($urandom);
      p.fon  = ($urandom_range(0, 2) == 0);
      p.fr   = 8'($urandom);
      p.fgg  = 8'($urandom);
      p.fbb  = 8'($urandom);
      return p;
   endfunction

   task automatic apply_px(input px_t p);
      hblank  = p.hb;
      sf_on   = p.son;
      sf_star = p.star;
      fg_on   = p.fon;
      fg_r    = p.fr;
      fg_g    = p.fgg;
      fg_b    = p.fbb;
   endtask

   // Expected {blank, r, g, b} for a pixel under given fade/star/tint settings.
   function automatic logic [24:0] exp_px(input px_t p, input int lvl, input bit sen,
                                          input logic [2:0] tnt);
      int lum;
      if (p.hb) return {1'b1, 24'h0};
      if (p.fon) return {1'b0, p.fr, p.fgg, p.fbb};
      if (sen && p.son) begin
         lum = (int'(p.star) * lvl) / 256;
         return {1'b0, tnt[2] ? 8'(lum) : 8'h0, tnt[1] ? 8'(lum) : 8'h0,
                 tnt[0] ? 8'(lum) : 8'h0};
      end
      return 25'h0;
   endfunction

   task automatic model_reset();
      m_level  = 0;
      m_fading = 0;
      m_up     = 0;
      m_sen    = 0;
      m_tint   = 3'b111;
   endtask

   task automatic model_edge();
      if (m_fading) begin
         if (m_up) m_level = (m_level + 4 > 255) ? 255 : m_level + 4;
         else      m_level = (m_level - 4 < 0) ? 0 : m_level - 4;
         if (m_level == (m_up ? 255 : 0)) m_fading = 0;
      end
   endtask

   task automatic cpu_wr(input logic a, input logic [7:0] d);
      addr    = a;
      data_in = d;
      write   = 1'b1;
      tick();
      write   = 1'b0;
      if (a == 1'b0) begin
         m_fading = 1;
         m_up     = d[1];
         m_sen    = d[0];
      end else begin
         m_tint = d[2:0];
      end
   endtask

   task automatic vb_edge(input string tag);
      vblank = 1'b1;
      tick();
      model_edge();
      check({tag, "_level"}, dut.u_fade.level, 32'(m_level));
      check({tag, "_fading"}, fading, m_fading);
      vblank = 1'b0;
      tick();
   endtask

   initial begin
      px_t p, fgp;
      logic [24:0] held;

      // Reset with random inputs
      model_reset();
      rst = 1'b1; en = 1'b1; write = 1'b0; addr = 1'b0; data_in = 8'h00;
      for (int i = 0; i < 3; i++) begin
         vblank = 1'($urandom); apply_px(rand_px());
         addr = 1'($urandom); data_in = 8'($urandom); write = 1'($urandom);
         tick();
      end
      write = 1'b0;
      check("rst_rgb", {r, g, b}, 0);
      check("rst_blank", blank_out, 1);
      check("rst_fading", fading, 0);
      check("rst_level", dut.u_fade.level, 0);

      rst = 1'b0; vblank = 1'b0;
      fgp = rand_px(); fgp.hb = 1'b0; fgp.fon = 1'b1;
      apply_px(fgp);
      tick();
      check("rst_latency", {blank_out, r, g, b}, {1'b1, 24'h0});
      tick();
      check("first_px", {blank_out, r, g, b}, exp_px(fgp, m_level, m_sen, m_tint));

      // Fade in over 64 frames, then one extra frame at full level
      cpu_wr(1'b0, {6'($urandom), 2'b11});
      check("fade_start", fading, 1);
      for (int i = 1; i <= 64; i++) vb_edge("fade_in");
      check("fade_in_top", dut.u_fade.level, 255);
      vb_edge("fade_in_65");
      check("fade_in_idle", fading, 0);

      // Star path at full level, red tint only
      cpu_wr(1'b1, 8'hA4);
      p.hb = 0; p.son = 1; p.star = 8'h80; p.fon = 0; p.fr = 0; p.fgg = 0; p.fbb = 0;
      apply_px(p);
      tick(); tick();
      check("star_red", {blank_out, r, g, b}, {1'b0, 24'h7F0000});

      // Foreground priority and horizontal blanking
      p.fon = 1; p.fr = 8'h11; p.fgg = 8'h22; p.fbb = 8'h33;
      apply_px(p);
      tick(); tick();
      check("fg_prio", {blank_out, r, g, b}, {1'b0, 24'h112233});
      hblank = 1'b1;
      tick(); tick();
      check("hblank", {blank_out, r, g, b}, {1'b1, 24'h0});
      hblank = 1'b0;

      // Random pixel streams under random tint and star enable
      for (int rnd = 0; rnd < 4; rnd++) begin
         cpu_wr(1'b1, 8'($urandom));
         cpu_wr(1'b0, {6'($urandom), 1'b1, 1'($urandom)});
         q.delete();
         for (int k = 0; k < 16; k++) begin
            p = rand_px();
            apply_px(p);
            q.push_back(p);
            tick();
            if (q.size() >= 2)
               check("rand_px", {blank_out, r, g, b},
                     exp_px(q[q.size() - 2], m_level, m_sen, m_tint));
         end
      end

      // Reset beats a same-cycle control write
      addr = 1'b0; data_in = 8'h03; write = 1'b1; rst = 1'b1;
      tick();
      write = 1'b0; rst = 1'b0;
      model_reset();
      check("rst_vs_wr_fading", fading, 0);
      check("rst_vs_wr_level", dut.u_fade.level, 0);

      // Retarget colliding with a frame edge at level 40
      cpu_wr(1'b0, 8'h03);
      for (int i = 0; i < 10; i++) vb_edge("pre_retarget");
      check("at_40", dut.u_fade.level, 40);
      addr = 1'b0; data_in = 8'h01; write = 1'b1; vblank = 1'b1;
      tick();
      write = 1'b0;
      m_up = 0; m_sen = 1; m_fading = 1;
      check("collide_level", dut.u_fade.level, 40);
      check("collide_fading", fading, 1);
      vblank = 1'b0;
      tick();
      for (int i = 0; i < 10; i++) vb_edge("fade_out");
      check("fade_out_zero", dut.u_fade.level, 0);
      check("fade_out_idle", fading, 0);

      // Reset in the middle of a fade at level 100
      cpu_wr(1'b0, 8'h03);
      for (int i = 0; i < 25; i++) vb_edge("to_100");
      check("at_100", dut.u_fade.level, 100);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      model_reset();
      check("midfade_rst_level", dut.u_fade.level, 0);
      check("midfade_rst_fading", fading, 0);

      // Clock-enable gating freezes outputs and the fade
      cpu_wr(1'b0, 8'h03);
      vb_edge("pre_gate");
      vb_edge("pre_gate");
      fgp = rand_px(); fgp.hb = 1'b0; fgp.fon = 1'b1;
      apply_px(fgp);
      tick(); tick();
      held = exp_px(fgp, m_level, m_sen, m_tint);
      check("pre_gate_px", {blank_out, r, g, b}, held);
      en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         apply_px(rand_px()); hblank = 1'b1;
         vblank = 1'b1; tick();
         vblank = 1'b0; tick();
      end
      check("gated_level", dut.u_fade.level, 8);
      check("gated_px", {blank_out, r, g, b}, held);
      en = 1'b1; hblank = 1'b0;
      vb_edge("post_gate");
      check("post_gate_level", dut.u_fade.level, 12);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/starfield_compositor.md
# starfield_compositor

Pixel-rate compositing stage directly downstream of the starfield generator. It consumes the generator's `sf_on`/`sf_star` stream and blends it behind the foreground video layer, producing final RGB for the video output. It also applies a CPU-controlled brightness fade that ramps once per frame, and a per-channel star tint. The block adds a fixed two-pixel pipeline delay.

## Interface
Parameters:
- `FADE_STEP`, default 8'd4: brightness change applied per frame while fading.
- `TINT_RESET`, default 3'b111: reset value of the tint register, as {R,G,B} channel enables.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `en` in 1: pixel clock enable; the pipeline and vblank sampling advance only when `en`=1.
- `vblank` in 1: vertical blank from video timing.
- `hblank` in 1: horizontal blank from video timing.
- `sf_on` in 1: star present, from the starfield generator.
- `sf_star` in 8: star brightness, from the starfield generator.
- `fg_on` in 1: foreground pixel opaque.
- `fg_r`, `fg_g`, `fg_b` in 8 each: foreground colour.
- `addr` in 1: CPU register select (0 = control, 1 = tint).
- `data_in` in 8: CPU write data.
- `write` in 1: CPU write strobe, one clk wide, independent of `en`.
- `r`, `g`, `b` out 8 each: composited colour.
- `blank_out` out 1: `hblank|vblank`, delayed to match the colour outputs.
- `fading` out 1: high while a fade is in progress.

## Operation
- **Control register (addr 0)**:
  - bit0 `star_en` gates stars.
  - bit1 `fade_dir` selects the fade target: 1 = fade in to 255, 0 = fade out to 0.
  - bits 7:2 are ignored.
  - Every write to addr 0 loads both bits and enters FADING with the new target.
- **Tint register (addr 1)**: bits 2:0 are {R,G,B} enables; the upper bits are ignored.
- **Fade state machine**, states IDLE and FADING, 8-bit `level`:
  - `vblank` is sampled into `vblank_d` on every `en` cycle. A rising edge is `en & vblank & ~vblank_d`.
  - In FADING, on a rising edge, `level` steps toward the target by `FADE_STEP`, saturating at 0 and 255.
  - When `level` equals the target after a step, the state returns to IDLE.
  - If `level` already equals the target when the write occurs, the state stays FADING for one frame edge, then goes to IDLE with `level` unchanged.
  - A write during FADING retargets immediately and keeps the current `level`.
  - A write and a vblank edge in the same clk: the write wins and no step is applied that cycle.
  - `fading` = (state == FADING).
- **Pixel pipeline** (advances on `en` only):
  - Stage 1 registers `sf_on`, `sf_star`, `fg_*`, `fg_on`, and blank = `hblank|vblank`.
  - Stage 2 computes `lum` = upper byte of the 16-bit product `sf_star*level`. With `level`=255 this gives `sf_star`−1 for nonzero input; this is accepted.
  - Output priority:
    1. If blank, the output is 0.
    2. Else if `fg_on`, the output is `fg_*`.
    3. Else if `star_en & sf_on`, each channel is `lum` where its tint bit is 1, otherwise 0.
    4. Else 0.
  - `level`, `star_en` and tint are sampled at stage 2 from the current register values. There is no shadowing, so a mid-line write takes effect on the next stage-2 pixel.

## Timing
- Latency is 2 `en` cycles from inputs to `r`/`g`/`b`/`blank_out`. Outputs hold when `en`=0.
- Register writes are visible to stage 2 on the clk after `write`.
- A fade from 0 to 255 with `FADE_STEP`=4 takes 64 frames; the last step saturates from 252 to 255.
- Reset values:
  - `r`,`g`,`b` = 0, `blank_out` = 1, `fading` = 0.
  - `level` = 0, state IDLE, `star_en` = 0, `fade_dir` = 0, tint = `TINT_RESET`.
  - `vblank_d` = 0, pipeline registers 0 with blank = 1.
- `rst` asserted mid-fade aborts the fade to the reset values on the next clk. `rst` has priority over `write` in the same clk.

## Structure
- Shared package `starfield_pkg`:
  - register addresses `SF_REG_CTRL`=0 and `SF_REG_TINT`=1;
  - control bit indices;
  - fade state encoding `SF_FADE_IDLE`/`SF_FADE_RUN`.
- One sub-module, `starfield_fade`: vblank edge detect, state machine, and saturating `level` ramp. Ports: `clk`, `rst`, `en`, `vblank`, `start`, `dir`, outputs `level`, `fading`.
- The pipeline and register file live in the top module.

## Test plan
- **Reset**: assert `rst` with random inputs, then release → `r`/`g`/`b`=0, `blank_out`=1, `fading`=0 until two `en` cycles of valid input have passed.
- **Fade in**: write ctrl=0x03, then pulse 64 vblank rising edges → `level` goes 4, 8, …, 252, 255. `fading` drops on edge 64, and a 65th edge leaves `level`=255.
- **Star path**: `level`=255, tint=3'b100, `sf_on`=1, `sf_star`=0x80, `fg_on`=0 → two `en` cycles later `r`=0x7F, `g`=0, `b`=0.
- **Foreground priority**: `fg_on`=1 with fg=(0x11,0x22,0x33) and a star present → output (0x11,0x22,0x33). Asserting `hblank` → output 0 with `blank_out`=1.
- **Retarget and collision**: during a fade-in at `level`=40, write ctrl=0x01 in the same clk as a vblank edge → `level` stays 40; the next edges give 36, 32, …, 0, then IDLE.
- **`en` gating and mid-fade reset**: hold `en`=0 → outputs and `level` frozen despite vblank toggling. `rst` at `level`=100 → `level`=0 and IDLE next clk.
